// File: rtl/axil_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_cmd_master_if
// Description : AXI4-Lite bus bundle (AW, W, B, AR, R channels) shared by
//               axil_cmd_master and whatever slave it drives.
//   master modport : drives addresses, data, strobes, valids and B/R readies
//   slave  modport : drives AW/W/AR readies and the B/R responses
// Revision    : 1.0  initial release
// ============================================================================
interface axil_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // AW channel
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    // W channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    // B channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // AR channel
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    // R channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_cmd_master
// Description : Bridges a single-beat register command stream (valid/ready)
//               onto an AXI4-Lite master port. One transaction in flight;
//               one response per command; a watchdog aborts a hung slave.
// Ports       :
//   ACLK, ARESETN         clock, synchronous active-low reset
//   cmd_*                 command in (write flag, address, data, strobes)
//   rsp_*                 response out (read data, resp code, timeout flag)
//   m_axil                AXI4-Lite master bundle (axil_cmd_master_if.master)
// Revision    : 1.0  initial release
// ============================================================================
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire                      ACLK,
    input  wire                      ARESETN,
    input  wire                      cmd_valid,
    output logic                     cmd_ready,
    input  wire                      cmd_write,
    input  wire [ADDR_WIDTH-1:0]     cmd_addr,
    input  wire [DATA_WIDTH-1:0]     cmd_wdata,
    input  wire [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                     rsp_valid,
    input  wire                      rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     rsp_timeout,
    axil_cmd_master_if.master        m_axil
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit c_WD_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [c_WD_W-1:0] c_WD_LAST =
        c_WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [c_STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
    logic                  r_awvalid, w_awvalid_nxt;
    logic                  r_wvalid, w_wvalid_nxt;
    logic                  r_bready, w_bready_nxt;
    logic                  r_arvalid, w_arvalid_nxt;
    logic                  r_rready, w_rready_nxt;
    logic                  r_aw_done, w_aw_done_nxt;
    logic                  r_w_done, w_w_done_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]            r_resp, w_resp_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic [c_WD_W-1:0]     r_wd, w_wd_nxt;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_wd_last;
    logic w_abort;

    assign w_aw_hs   = r_awvalid & m_axil.awready;
    assign w_w_hs    = r_wvalid  & m_axil.wready;
    assign w_b_hs    = r_bready  & m_axil.bvalid;
    assign w_ar_hs   = r_arvalid & m_axil.arready;
    assign w_r_hs    = r_rready  & m_axil.rvalid;
    assign w_wd_last = c_WD_EN && (r_wd == c_WD_LAST);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_rdata_nxt   = r_rdata;
        w_resp_nxt    = r_resp;
        w_timeout_nxt = r_timeout;
        w_wd_nxt      = c_WD_EN ? (r_wd + c_WD_W'(1)) : '0;
        w_abort       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Watchdog is zeroed here so every wait state starts at 0.
                w_wd_nxt = '0;
                if (cmd_valid) begin
                    w_addr_nxt    = cmd_addr;
                    w_wdata_nxt   = cmd_wdata;
                    w_wstrb_nxt   = cmd_wstrb;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    if (cmd_write) begin
                        w_state_nxt   = ST_WR_AW_W;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RD_AR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR_AW_W: begin
                // AW and W complete independently; each valid falls right
                // after its own handshake and the sticky flags remember it.
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done  | w_w_hs;
                if (w_aw_hs) w_awvalid_nxt = 1'b0;
                if (w_w_hs)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt  = ST_WR_B;
                    w_bready_nxt = 1'b1;
                    w_wd_nxt     = '0;
                end else if (w_wd_last) begin
                    w_abort = 1'b1;
                end
            end
            ST_WR_B: begin
                if (w_b_hs) begin
                    w_bready_nxt  = 1'b0;
                    w_resp_nxt    = m_axil.bresp;
                    w_rdata_nxt   = '0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_RSP;
                end else if (w_wd_last) begin
                    w_abort = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_R;
                    w_wd_nxt      = '0;
                end else if (w_wd_last) begin
                    w_abort = 1'b1;
                end
            end
            ST_RD_R: begin
                if (w_r_hs) begin
                    w_rready_nxt  = 1'b0;
                    w_rdata_nxt   = m_axil.rdata;
                    w_resp_nxt    = m_axil.rresp;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_RSP;
                end else if (w_wd_last) begin
                    w_abort = 1'b1;
                end
            end
            ST_RSP: begin
                w_wd_nxt = '0;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Watchdog abort: withdraw everything from the bus and report SLVERR.
        if (w_abort) begin
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_resp_nxt    = c_RESP_SLVERR;
            w_timeout_nxt = 1'b1;
            w_rdata_nxt   = '0;
            w_state_nxt   = ST_RSP;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= '0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
        end else begin
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_resp    <= w_resp_nxt;
            r_timeout <= w_timeout_nxt;
            r_wd      <= w_wd_nxt;
        end
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RSP);
    assign rsp_rdata   = r_rdata;
    assign rsp_resp    = r_resp;
    assign rsp_timeout = r_timeout;

    assign m_axil.awaddr  = r_addr;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;
    assign m_axil.araddr  = r_addr;
    assign m_axil.arvalid = r_arvalid;
    assign m_axil.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_cmd_master
// Description : Directed self-checking bench for axil_cmd_master with a small
//               AXI4-Lite memory slave whose ready/response timing is set
//               per test (AW/W skew, AR stall, B hold, forced BRESP).
// Revision    : 1.0  initial release
// ============================================================================
module tb_axil_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    always #5 ACLK = ~ACLK;

    axil_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

    axil_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axil(axil)
    );

    // ---------------- slave model ----------------
    int          aw_wait = 0;
    int          w_wait = 0;
    logic        ar_stall = 1'b0;
    logic        b_hold = 1'b0;
    logic [1:0]  bresp_knob = 2'b00;
    int          aw_cnt, w_cnt;
    int          aw_hs_n = 0;
    int          w_hs_n = 0;
    logic        s_aw_got, s_w_got, s_bvalid, s_rvalid;
    logic [31:0] s_awaddr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;
    logic [31:0] mem [16];
    logic        aw_hs, w_hs;
    logic [31:0] sl_addr, sl_data, sl_merged;
    logic [3:0]  sl_strb;

    assign axil.awready = axil.awvalid && (aw_cnt >= aw_wait);
    assign axil.wready  = axil.wvalid && (w_cnt >= w_wait);
    assign axil.arready = axil.arvalid && !ar_stall;
    assign axil.bvalid  = s_bvalid;
    assign axil.bresp   = s_bresp;
    assign axil.rvalid  = s_rvalid;
    assign axil.rdata   = s_rdata;
    assign axil.rresp   = 2'b00;

    assign aw_hs   = axil.awvalid && axil.awready;
    assign w_hs    = axil.wvalid && axil.wready;
    assign sl_addr = aw_hs ? axil.awaddr : s_awaddr;
    assign sl_data = w_hs ? axil.wdata : s_wdata;
    assign sl_strb = w_hs ? axil.wstrb : s_wstrb;

    always_comb begin
        sl_merged = mem[sl_addr[5:2]];
        for (int b = 0; b < 4; b++) begin
            if (sl_strb[b]) sl_merged[8*b +: 8] = sl_data[8*b +: 8];
        end
    end

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_cnt   <= 0;
            w_cnt    <= 0;
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            s_awaddr <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            s_rdata  <= '0;
            s_bresp  <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            aw_cnt <= (axil.awvalid && !axil.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axil.wvalid && !axil.wready) ? w_cnt + 1 : 0;
            if (aw_hs) begin
                s_aw_got <= 1'b1;
                s_awaddr <= axil.awaddr;
                aw_hs_n  <= aw_hs_n + 1;
            end
            if (w_hs) begin
                s_w_got <= 1'b1;
                s_wdata <= axil.wdata;
                s_wstrb <= axil.wstrb;
                w_hs_n  <= w_hs_n + 1;
            end
            if ((s_aw_got || aw_hs) && (s_w_got || w_hs) && !s_bvalid && !b_hold) begin
                mem[sl_addr[5:2]] <= sl_merged;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= bresp_knob;
            end
            if (s_bvalid && axil.bready) s_bvalid <= 1'b0;
            if (axil.arvalid && axil.arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[axil.araddr[5:2]];
            end else if (s_rvalid && axil.rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Present a command and return in the cycle after it was accepted.
    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("cmd_accept_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output logic to);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        rd = rsp_rdata;
        rs = rsp_resp;
        to = rsp_timeout;
        if (n >= 200) begin
            check("rsp_wait", 64'(rsp_valid), 64'd1);
        end else begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got stuck, expected completion");
        $fatal(1, "bench stuck");
    end

    initial begin : stim
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;
        int          n, aw0, w0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_awvalid", 64'(axil.awvalid), 64'd0);
        check("rst_wvalid", 64'(axil.wvalid), 64'd0);
        check("rst_arvalid", 64'(axil.arvalid), 64'd0);
        check("rst_bready_rready", 64'({axil.bready, axil.rready}), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_fields", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
        check("rst_awaddr", 64'(axil.awaddr), 64'd0);
        ARESETN = 1'b1;
        tick();

        // Zero-wait write, cycle exact
        send_cmd(1'b1, 32'h004, 32'hDEADBEEF, 4'hF);
        check("wr_c1_aw_w_valid", 64'({axil.awvalid, axil.wvalid}), 64'h3);
        check("wr_c1_awaddr", 64'(axil.awaddr), 64'h004);
        check("wr_c1_wdata", 64'(axil.wdata), 64'hDEADBEEF);
        check("wr_c1_wstrb", 64'(axil.wstrb), 64'hF);
        tick();
        check("wr_c2_bready", 64'(axil.bready), 64'd1);
        check("wr_c2_valids_low", 64'({axil.awvalid, axil.wvalid}), 64'd0);
        check("wr_c2_no_rsp", 64'(rsp_valid), 64'd0);
        tick();
        check("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        wait_rsp(rd, rs, to);
        check("wr_resp", 64'(rs), 64'd0);
        check("wr_timeout", 64'(to), 64'd0);
        check("wr_rdata_zero", 64'(rd), 64'd0);
        check("wr_cmd_ready_after", 64'(cmd_ready), 64'd1);

        // Readback
        send_cmd(1'b0, 32'h004, 32'h0, 4'h0);
        check("rd_arvalid", 64'(axil.arvalid), 64'd1);
        check("rd_araddr", 64'(axil.araddr), 64'h004);
        wait_rsp(rd, rs, to);
        check("rd_004_data", 64'(rd), 64'hDEADBEEF);
        check("rd_004_resp", 64'(rs), 64'd0);
        send_cmd(1'b0, 32'h00C, 32'h0, 4'h0);
        wait_rsp(rd, rs, to);
        check("rd_00c_data", 64'(rd), 64'h0);

        // AW/W skew: W ready at once, AW ready 3 cycles later
        aw_wait = 3;
        w_wait  = 0;
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        send_cmd(1'b1, 32'h008, 32'h12345678, 4'hF);
        tick();
        check("skew_wvalid_dropped", 64'(axil.wvalid), 64'd0);
        check("skew_awvalid_held", 64'(axil.awvalid), 64'd1);
        wait_rsp(rd, rs, to);
        check("skew_resp", 64'(rs), 64'd0);
        check("skew_aw_beats", 64'(aw_hs_n - aw0), 64'd1);
        check("skew_w_beats", 64'(w_hs_n - w0), 64'd1);
        // Same-cycle readies after equal waits, partial strobe
        aw_wait = 2;
        w_wait  = 2;
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        send_cmd(1'b1, 32'h010, 32'hCAFEF00D, 4'h3);
        wait_rsp(rd, rs, to);
        check("same_resp", 64'(rs), 64'd0);
        check("same_aw_beats", 64'(aw_hs_n - aw0), 64'd1);
        check("same_w_beats", 64'(w_hs_n - w0), 64'd1);
        aw_wait = 0;
        w_wait  = 0;
        send_cmd(1'b0, 32'h008, 32'h0, 4'h0);
        wait_rsp(rd, rs, to);
        check("rd_008_data", 64'(rd), 64'h12345678);
        send_cmd(1'b0, 32'h010, 32'h0, 4'h0);
        wait_rsp(rd, rs, to);
        check("rd_010_strb_data", 64'(rd), 64'h0000F00D);

        // Response backpressure with a second command waiting
        send_cmd(1'b0, 32'h004, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h008;
        for (int i = 0; i < 4; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rdata_stable", 64'(rsp_rdata), 64'hDEADBEEF);
            check("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("bp_not_yet_issued", 64'(axil.arvalid), 64'd0);
        tick();
        cmd_valid = 1'b0;
        check("bp_second_arvalid", 64'(axil.arvalid), 64'd1);
        check("bp_second_araddr", 64'(axil.araddr), 64'h008);
        wait_rsp(rd, rs, to);
        check("bp_second_data", 64'(rd), 64'h12345678);

        // Watchdog on a slave that never raises arready
        ar_stall = 1'b1;
        send_cmd(1'b0, 32'h020, 32'h0, 4'h0);
        n = 0;
        while (axil.arvalid && n < 100) begin
            n++;
            tick();
        end
        check("to_ar_cycles", 64'(n), 64'd16);
        check("to_rsp_valid", 64'(rsp_valid), 64'd1);
        wait_rsp(rd, rs, to);
        check("to_resp", 64'(rs), 64'h2);
        check("to_flag", 64'(to), 64'd1);
        check("to_rdata", 64'(rd), 64'd0);
        ar_stall = 1'b0;
        send_cmd(1'b0, 32'h004, 32'h0, 4'h0);
        wait_rsp(rd, rs, to);
        check("after_to_data", 64'(rd), 64'hDEADBEEF);
        check("after_to_flags", 64'({rs, to}), 64'd0);

        // Slave error passthrough
        bresp_knob = 2'b11;
        send_cmd(1'b1, 32'h014, 32'h11111111, 4'hF);
        wait_rsp(rd, rs, to);
        check("err_bresp", 64'(rs), 64'h3);
        check("err_timeout", 64'(to), 64'd0);
        bresp_knob = 2'b00;

        // Reset while waiting in WR_B
        b_hold = 1'b1;
        send_cmd(1'b1, 32'h018, 32'h00000001, 4'hF);
        n = 0;
        while (!axil.bready && n < 20) begin
            tick();
            n++;
        end
        check("rstb_bready_seen", 64'(axil.bready), 64'd1);
        ARESETN = 1'b0;
        tick();
        check("rstb_bready", 64'(axil.bready), 64'd0);
        check("rstb_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rstb_rsp_valid", 64'(rsp_valid), 64'd0);
        ARESETN = 1'b1;
        b_hold  = 1'b0;
        tick();
        send_cmd(1'b1, 32'h01C, 32'hA5A55A5A, 4'hC);
        wait_rsp(rd, rs, to);
        check("rstb_wr_resp", 64'(rs), 64'd0);
        send_cmd(1'b0, 32'h01C, 32'h0, 4'h0);
        wait_rsp(rd, rs, to);
        check("rstb_rd_data", 64'(rd), 64'hA5A50000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
